rom_capture_stack: RTL and testbench

ROM_CAPTURE_STACK -- requirements
Module: rom_capture_stack

---
 rtl/rom_capture_stack.sv | 136 +++++++++++++
 tb/tb_rom_capture_stack.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rom_capture_stack.sv
// rom_capture_stack
//   Captures ROM words as {addr, data} pairs into a LIFO stack and returns
//   them on request. Popped entries appear on out_data/out_addr one cycle
//   after the pop edge, and out_valid marks that cycle. Occupancy is
//   reported as a count plus registered full/empty flags. Overflow,
//   underflow and address-sequence errors are sticky until reset.
//
//   Optional feature macro: ROM_CAPTURE_ADDR_CHECK_EN
//     When defined, each accepted push is checked against the address that
//     follows the previously accepted push, with wrap from all-ones to 0.
//     Any mismatch sets addr_err. When undefined, addr_err is tied to 0.
//
//   Handshake: an upstream word is accepted when in_valid=1 and the stack is
//   not full, or when a pop is accepted in the same cycle. A pop is accepted
//   when pop=1 and the stack is not empty. Nothing stalls upstream. A word
//   that is not accepted is dropped.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_data/in_addr   upstream ROM word
//   pop                 remove the top entry
//   out_valid/out_data/out_addr  popped entry (held while out_valid=0)
//   count, full, empty  occupancy
//   overflow, underflow, addr_err  sticky error flags
//   fsm_state           occupancy state for debug (0 EMPTY, 1 PARTIAL, 2 FULL)
module rom_capture_stack #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic                        pop,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        addr_err,
  output logic [1:0]                  fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];

  logic            pop_ok;
  logic            push_ok;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   wr_idx;
  logic [CW-1:0]   count_nxt;

  assign fsm_state = state;

  // A full stack still accepts a push when a pop is accepted in the same
  // cycle, because the popped slot is reused for the new word.
  assign pop_ok  = pop && !empty;
  assign push_ok = in_valid && (!full || pop_ok);

  // When count == DEPTH the low bits wrap to 0, so top_idx becomes
  // DEPTH-1, which is the top slot.
  assign top_idx = count[AW-1:0] - AW'(1);
  assign wr_idx  = pop_ok ? top_idx : count[AW-1:0];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + CW'(1);
    else if (pop_ok && !push_ok) count_nxt = count - CW'(1);
  end

  // Storage is not reset. Entries beyond count are never read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= {in_addr, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CW'(DEPTH));
      out_valid <= pop_ok;
      if (pop_ok) {out_addr, out_data} <= mem[top_idx];
      if (in_valid && full && !pop) overflow  <= 1'b1;
      if (pop && empty)             underflow <= 1'b1;
      if (count_nxt == '0)                state <= S_EMPTY;
      else if (count_nxt == CW'(DEPTH))   state <= S_FULL;
      else                                state <= S_PARTIAL;
    end
  end

`ifdef ROM_CAPTURE_ADDR_CHECK_EN
  logic                  have_exp;
  logic [ADDR_WIDTH-1:0] exp_addr;

  // Dropped words never reach this block because it only acts on push_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_exp <= 1'b0;
      exp_addr <= '0;
      addr_err <= 1'b0;
    end else if (push_ok) begin
      have_exp <= 1'b1;
      exp_addr <= in_addr + ADDR_WIDTH'(1);
      if (have_exp && (in_addr != exp_addr)) addr_err <= 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_capture_stack.sv
// Bench for rom_capture_stack (DEPTH=16, DATA_WIDTH=8, ADDR_WIDTH=10).
// A reference stack is kept in a queue. Entries popped from it are pushed to
// exp_q when the pop is driven, and popped again when out_valid is seen.
module tb_rom_capture_stack;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int D  = 16;
  localparam int EW = AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          pop;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [4:0]    count;
  logic          full, empty, overflow, underflow, addr_err;
  logic [1:0]    fsm_state;

  rom_capture_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_addr(in_addr), .pop(pop), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .addr_err(addr_err),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] stk[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_out;
  logic          m_ovf, m_unf, m_aerr, m_have;
  logic [AW-1:0] m_exp_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    stk.delete();
    exp_q.delete();
    last_out = '0;
    m_ovf = 0; m_unf = 0; m_aerr = 0; m_have = 0; m_exp_addr = '0;
  endtask

  task automatic check_state(input string tag);
    int n;
    n = stk.size();
    check_eq({tag, ".count"}, 32'(count), 32'(n));
    check_eq({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check_eq({tag, ".full"}, 32'(full), 32'(n == D));
    check_eq({tag, ".state"}, 32'(fsm_state), (n == 0) ? 32'd0 : (n == D) ? 32'd2 : 32'd1);
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check_eq({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    check_eq({tag, ".addr_err"}, 32'(addr_err), 32'(m_aerr));
  endtask

  // Called on a negedge; drives one cycle, checks after the edge, returns on
  // the next negedge.
  task automatic step(input logic iv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic p, input string tag);
    bit pop_ok, full_m, expect_out;
    in_valid = iv; in_addr = a; in_data = d; pop = p;
    full_m = (stk.size() == D);
    pop_ok = p && (stk.size() != 0);
    if (iv && full_m && !p) m_ovf = 1;
    if (p && stk.size() == 0) m_unf = 1;
    if (pop_ok) exp_q.push_back(stk.pop_back());
    if (iv && (!full_m || p)) begin
      stk.push_back({a, d});
`ifdef ROM_CAPTURE_ADDR_CHECK_EN
      if (m_have && a != m_exp_addr) m_aerr = 1;
      m_have = 1;
      m_exp_addr = a + AW'(1);
`endif
    end
    expect_out = pop_ok;
    @(posedge clk);
    #1;
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(expect_out));
    if (out_valid && exp_q.size() != 0) last_out = exp_q.pop_front();
    check_eq({tag, ".out_data"}, 32'(out_data), 32'(last_out[DW-1:0]));
    check_eq({tag, ".out_addr"}, 32'(out_addr), 32'(last_out[EW-1:DW]));
    check_state(tag);
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    in_valid = 0; pop = 0;
    rst = 1;
    #1;
    model_clear();
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".out_data"}, 32'(out_data), 32'd0);
    check_eq({tag, ".out_addr"}, 32'(out_addr), 32'd0);
    check_state(tag);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_addr = '0; pop = 0;
    model_clear();
    #1;
    check_eq("por.count", 32'(count), 32'd0);
    check_eq("por.empty", 32'(empty), 32'd1);
    apply_reset("reset0");

    // LIFO order
    for (int i = 0; i < 4; i++) step(1, AW'(i), DW'(8'h10 + i), 0, "lifo_push");
    for (int i = 0; i < 4; i++) step(0, '0, '0, 1, "lifo_pop");

    // Underflow cases: pop on empty, then push+pop on empty
    step(0, '0, '0, 1, "unf_pop");
    step(1, AW'(4), 8'hA4, 1, "unf_pushpop");
    step(0, '0, '0, 1, "unf_drain");

    // Fill to DEPTH, 17th dropped
    apply_reset("reset1");
    for (int i = 0; i < 17; i++) step(1, AW'(i), DW'(8'h20 + i), 0, "fill");
    step(0, '0, '0, 1, "fill_pop");
    step(1, AW'(16), 8'h30, 0, "refill");
    step(1, AW'(17), 8'h55, 1, "full_pushpop");
    step(0, '0, '0, 1, "pop_55");

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 1023)),
           DW'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0), "rand");

    // Asynchronous reset with 5 entries and a pop requested
    apply_reset("reset2");
    for (int i = 0; i < 5; i++) step(1, AW'(i), DW'(8'h40 + i), 0, "pre_rst");
    pop = 1;
    #2;
    rst = 1;
    #1;
    model_clear();
    check_eq("async_rst.out_valid", 32'(out_valid), 32'd0);
    check_state("async_rst");
    @(negedge clk);
    pop = 0;
    rst = 0;
    step(0, '0, '0, 0, "post_rst");

    // Address sequence with wrap
    step(1, AW'(1022), 8'h01, 0, "aseq_1022");
    step(1, AW'(1023), 8'h02, 0, "aseq_1023");
    step(1, AW'(0),    8'h03, 0, "aseq_0");
    check_eq("aseq_before_gap", 32'(addr_err), 32'd0);
    step(1, AW'(2),    8'h04, 0, "aseq_2");
`ifdef ROM_CAPTURE_ADDR_CHECK_EN
    check_eq("aseq_gap", 32'(addr_err), 32'd1);
`else
    check_eq("aseq_gap", 32'(addr_err), 32'd0);
`endif
    step(0, '0, '0, 1, "aseq_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
